// File: rtl/cache_arbiter.sv
// Arbitrates one physical-memory port between the I-cache and D-cache.
// Optional round-robin tie-break enabled by defining CACHE_ARB_ROUND_ROBIN_EN.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic [127:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic [127:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 128;
    localparam logic [ADDR_W-1:0] LINE_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              read_nx, write_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              i_req, d_req, grant_i, grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // last_d high means D was served most recently; a tie goes to the other side
    logic last_d, last_d_nx;
    assign grant_d = d_req & (~i_req | ~last_d);
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_req & ~grant_d;

    // Next-state and next-command selection
    always_comb begin
        state_nx = state;
        read_nx  = pmem_read;
        write_nx = pmem_write;
        addr_nx  = pmem_address;
        wdata_nx = pmem_wdata;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_d_nx = last_d;
`endif
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx = SERVE_D;
                    addr_nx  = d_pmem_address & LINE_MASK;
                    wdata_nx = d_pmem_wdata;
                    write_nx = d_pmem_write;
                    read_nx  = ~d_pmem_write;
                end else if (grant_i) begin
                    state_nx = SERVE_I;
                    addr_nx  = i_pmem_address & LINE_MASK;
                    read_nx  = 1'b1;
                    write_nx = 1'b0;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_nx = IDLE;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_d_nx = 1'b0;
`endif
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_nx = IDLE;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_d_nx = 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered memory command
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state        <= state_nx;
            pmem_read    <= read_nx;
            pmem_write   <= write_nx;
            pmem_address <= addr_nx;
            pmem_wdata   <= wdata_nx;
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) last_d <= 1'b0;
        else     last_d <= last_d_nx;
    end
`endif

    // Response is routed only to the requester currently being served
    assign i_pmem_resp  = pmem_resp & (state == SERVE_I);
    assign d_pmem_resp  = pmem_resp & (state == SERVE_D);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the port (0 none, 1 I, 2 D) and the command in flight
    int           m_owner = 0;
    int           m_last  = 1;
    logic         m_rd    = 1'b0;
    logic         m_wr    = 1'b0;
    logic [15:0]  m_addr  = '0;
    logic [127:0] m_wdata = '0;
    int           g_c;

    function automatic int pick(input bit iq, input bit dq, input int last);
        if (iq && dq) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            return (last == 1) ? 2 : 1;
`else
            return 2 + 0 * last;
`endif
        end
        if (dq) return 2;
        if (iq) return 1;
        return 0;
    endfunction

    always_comb g_c = pick(i_pmem_read, d_pmem_read | d_pmem_write, m_last);

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= 0; m_last <= 1; m_rd <= 1'b0; m_wr <= 1'b0;
            m_addr <= '0; m_wdata <= '0;
        end else if (m_owner == 0) begin
            if (g_c == 1) begin
                m_owner <= 1; m_rd <= 1'b1; m_wr <= 1'b0;
                m_addr <= i_pmem_address & 16'hFFF0;
            end else if (g_c == 2) begin
                m_owner <= 2; m_wr <= d_pmem_write; m_rd <= !d_pmem_write;
                m_addr <= d_pmem_address & 16'hFFF0; m_wdata <= d_pmem_wdata;
            end
        end else if (pmem_resp) begin
            m_last <= m_owner; m_owner <= 0; m_rd <= 1'b0; m_wr <= 1'b0;
        end
    end

    // Every-cycle comparison of DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            chk("pmem_read", pmem_read, m_rd);
            chk("pmem_write", pmem_write, m_wr);
            chk("pmem_address", pmem_address, m_addr);
            chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("i_pmem_resp", i_pmem_resp, pmem_resp && m_owner == 1);
            chk("d_pmem_resp", d_pmem_resp, pmem_resp && m_owner == 2);
            chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
            chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int seq [4];
    int exp_seq [4];
    int n;
    int lat;
    int i_resp_cnt;
    bit i_done, d_done;
    logic [1:0] op;

    initial begin
        rst = 1'b1; i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        cyc(); cyc();
        chk("reset_read", pmem_read, 1'b0);
        chk("reset_write", pmem_write, 1'b0);
        chk("reset_addr", pmem_address, 16'h0);
        chk("reset_wdata", pmem_wdata, 128'h0);
        rst = 1'b0;
        checking = 1'b1;

        // Lone I read, memory answers 3 cycles after the command
        i_pmem_address = 16'h1234; i_pmem_read = 1;
        cyc();
        chk("i_cmd_read", pmem_read, 1'b1);
        chk("i_cmd_addr", pmem_address, 16'h1230);
        chk("model_i_addr", m_addr, 16'h1230);
        repeat (3) cyc();
        pmem_rdata = {4{32'hDEADBEEF}}; pmem_resp = 1;
        #1;
        chk("i_resp_hi", i_pmem_resp, 1'b1);
        chk("i_resp_d_lo", d_pmem_resp, 1'b0);
        chk("i_rdata", i_pmem_rdata, {4{32'hDEADBEEF}});
        cyc();
        pmem_resp = 0; i_pmem_read = 0;
        #1;
        chk("i_resp_one_cycle", i_pmem_resp, 1'b0);
        chk("i_read_cleared", pmem_read, 1'b0);

        // D writeback with read and write both high: write wins
        d_pmem_address = 16'h8F0E; d_pmem_wdata = {16{8'hA5}};
        d_pmem_read = 1; d_pmem_write = 1;
        cyc();
        chk("d_wr_write", pmem_write, 1'b1);
        chk("d_wr_read", pmem_read, 1'b0);
        chk("d_wr_addr", pmem_address, 16'h8F00);
        chk("d_wr_wdata", pmem_wdata, {16{8'hA5}});
        cyc();
        pmem_resp = 1;
        #1;
        chk("d_resp_hi", d_pmem_resp, 1'b1);
        chk("d_resp_i_lo", i_pmem_resp, 1'b0);
        cyc();
        pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;

        // I served while D address wanders; then a stray response in IDLE
        i_pmem_address = 16'h0057; i_pmem_read = 1;
        cyc();
        d_pmem_address = 16'h7777; cyc();
        d_pmem_address = 16'h1119; cyc();
        chk("addr_stable", pmem_address, 16'h0050);
        pmem_resp = 1; cyc();
        pmem_resp = 0; i_pmem_read = 0; cyc();
        pmem_resp = 1;
        #1;
        chk("stray_i_resp", i_pmem_resp, 1'b0);
        chk("stray_d_resp", d_pmem_resp, 1'b0);
        cyc();
        pmem_resp = 0;
        chk("stray_no_cmd", pmem_read | pmem_write, 1'b0);
        d_pmem_read = 1; cyc();
        chk("after_stray_grant", pmem_read, 1'b1);
        chk("after_stray_addr", pmem_address, 16'h1110);
        pmem_resp = 1; cyc();
        pmem_resp = 0; d_pmem_read = 0; cyc();

        // Reset two cycles into SERVE_D abandons the transaction
        d_pmem_address = 16'h2222; d_pmem_read = 1;
        cyc(); cyc();
        rst = 1; cyc();
        rst = 0; d_pmem_read = 0;
        chk("rst_read", pmem_read, 1'b0);
        chk("rst_write", pmem_write, 1'b0);
        chk("rst_addr", pmem_address, 16'h0);
        chk("rst_wdata", pmem_wdata, 128'h0);
        chk("rst_d_resp", d_pmem_resp, 1'b0);
        cyc();
        d_pmem_address = 16'h3334; d_pmem_write = 1; d_pmem_wdata = {8{16'h5A5A}};
        cyc();
        chk("post_rst_write", pmem_write, 1'b1);
        chk("post_rst_addr", pmem_address, 16'h3330);
        pmem_resp = 1; cyc();
        pmem_resp = 0; d_pmem_write = 0; cyc();

        // Both requesting from reset, each re-requesting immediately
        rst = 1; cyc();
        rst = 0; i_pmem_read = 1; d_pmem_read = 1;
        i_pmem_address = 16'h0100; d_pmem_address = 16'h0200;
        i_resp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(pmem_read | pmem_write) && n < 20) begin cyc(); n++; end
            chk("tie_cmd_seen", pmem_read | pmem_write, 1'b1);
            cyc();
            pmem_resp = 1;
            #1;
            seq[k] = i_pmem_resp ? 1 : (d_pmem_resp ? 2 : 0);
            if (i_pmem_resp) i_resp_cnt++;
            cyc();
            pmem_resp = 0;
        end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        exp_seq = '{2, 1, 2, 1};
`else
        exp_seq = '{2, 2, 2, 2};
        chk("i_starved", 128'(i_resp_cnt), 128'(0));
`endif
        for (int k = 0; k < 4; k++) chk($sformatf("tie_grant_%0d", k), 128'(seq[k]), 128'(exp_seq[k]));
        i_pmem_read = 0; d_pmem_read = 0;
        cyc(); cyc();

        // Random traffic: caches hold until response, memory answers after 0..3 cycles
        lat = -1;
        for (int c = 0; c < 3000; c++) begin
            i_done = pmem_resp && m_owner == 1 && !rst;
            d_done = pmem_resp && m_owner == 2 && !rst;
            cyc();
            pmem_resp = 0; rst = 0;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 99) == 0) begin
                rst = 1; i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; lat = -1;
            end else begin
                if (i_done) begin
                    if ($urandom_range(0, 1) == 1) i_pmem_address = 16'($urandom);
                    else i_pmem_read = 0;
                end else if (!i_pmem_read) begin
                    i_pmem_address = 16'($urandom);
                    if ($urandom_range(0, 2) == 0) i_pmem_read = 1;
                end
                if (d_done || (!d_pmem_read && !d_pmem_write)) begin
                    d_pmem_address = 16'($urandom);
                    d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
                    op = 2'($urandom_range(1, 3));
                    if (d_done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0)) begin
                        d_pmem_read = op[0]; d_pmem_write = op[1];
                    end else begin
                        d_pmem_read = 0; d_pmem_write = 0;
                    end
                end
                if (m_owner != 0) begin
                    if (lat < 0) lat = $urandom_range(0, 3);
                    if (lat == 0) begin pmem_resp = 1; lat = -1; end
                    else lat--;
                end else if ($urandom_range(0, 9) == 0) begin
                    pmem_resp = 1;
                end
            end
        end
        cyc();
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. Each cache issues 128-bit line reads (and, for the D-cache, line writebacks) using a hold-until-response handshake. The arbiter grants one requester at a time, registers its command onto the memory port, and routes the memory response back to the granted requester only. It sits between the two cache controllers and physical memory (or L2).

## Interface
Parameters:
- none; widths are fixed by `lc3b_word` (16-bit address) and `lc3b_data` (128-bit line).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `i_pmem_read`  in  1  I-cache line-read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  16  I-cache line address.
- `i_pmem_rdata`  out  128  read line to I-cache.
- `i_pmem_resp`  out  1  I-cache completion, one cycle.
- `d_pmem_read`  in  1  D-cache line-read request; held until `d_pmem_resp`.
- `d_pmem_write`  in  1  D-cache line-writeback request; held until `d_pmem_resp`.
- `d_pmem_address`  in  16  D-cache line address.
- `d_pmem_wdata`  in  128  D-cache writeback line.
- `d_pmem_rdata`  out  128  read line to D-cache.
- `d_pmem_resp`  out  1  D-cache completion, one cycle.
- `pmem_read`  out  1  memory read command; registered.
- `pmem_write`  out  1  memory write command; registered.
- `pmem_address`  out  16  memory line address; registered, bits [3:0] forced to 0.
- `pmem_wdata`  out  128  memory write line; registered.
- `pmem_rdata`  in  128  memory read line.
- `pmem_resp`  in  1  memory completion, one cycle.

## Operation
- States are IDLE, SERVE_I, and SERVE_D. Reset enters IDLE.
- IDLE with no request pending: stay in IDLE.
- IDLE with only the I request pending:
  - Go to SERVE_I.
  - Load `pmem_read`=1, `pmem_write`=0, and `pmem_address`={i_pmem_address[15:4],4'b0}.
- IDLE with only a D request pending:
  - Go to SERVE_D.
  - Load `pmem_address`={d_pmem_address[15:4],4'b0} and `pmem_wdata`=`d_pmem_wdata`.
  - If `d_pmem_write` is set, load `pmem_write`=1 and `pmem_read`=0, even when `d_pmem_read` is also set (write wins). Otherwise load `pmem_read`=1.
- IDLE with both requests pending: the tie is resolved per Configuration.
- SERVE_x holds the registered command constant until `pmem_resp`. Requester inputs are ignored while in SERVE_x.
- SERVE_x on `pmem_resp`:
  - `x_pmem_resp`=1 combinationally in the same cycle.
  - Next state is IDLE, and `pmem_read`/`pmem_write` clear.
  - `last_served` updates to x.
- `i_pmem_rdata` and `d_pmem_rdata` both equal `pmem_rdata` at all times.
- `i_pmem_resp` is `pmem_resp` gated by state==SERVE_I. `d_pmem_resp` is `pmem_resp` gated by state==SERVE_D.
- `pmem_resp` while in IDLE is ignored; no requester response and no state change.
- Reset values: state=IDLE, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `last_served`=I. Reset takes priority over every other event.
- Reset during SERVE_x abandons the transaction. No response is forwarded. Memory is reset by the same `rst`.

## Timing
- The grant decision happens in IDLE at cycle N. The memory command is visible at N+1, so there is one cycle of added request latency.
- Response latency is zero: `pmem_resp` at cycle M gives `x_pmem_resp` at M.
- After the response, the arbiter is back in IDLE at M+1. The earliest next command is at M+2, one bubble per transaction.
- A requester must deassert at M+1 unless it is issuing a new miss. A request still asserted in IDLE is treated as new.
- `pmem_read` and `pmem_write` are never both 1.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - On a tie in IDLE, grant the requester that is not `last_served`.
  - After reset, the first tie goes to D.
- Undefined:
  - Fixed priority; D always wins ties. I starves while D requests back-to-back.
  - `last_served` is unused and may be optimized away.

## Test plan
- Lone I read, addr 0x1234, memory responds 3 cycles after command:
  - `pmem_address`=0x1230 and `pmem_read`=1 from N+1.
  - `i_pmem_resp`=1 for exactly 1 cycle with rdata passed through.
  - `d_pmem_resp` stays 0.
- D writeback with `d_pmem_read` and `d_pmem_write` both high, addr 0x8F0E, wdata 0xA5…A5:
  - `pmem_write`=1, `pmem_read`=0, `pmem_address`=0x8F00, `pmem_wdata` matches.
- I and D asserted together from reset, each re-requesting immediately after its response:
  - Macro on: grants go D, I, D, I.
  - Macro off: all grants go to D and I never receives a response.
- I served; D address changes mid-transaction; stray `pmem_resp` in IDLE:
  - `pmem_address` stays stable until the response.
  - The stray response produces no `x_pmem_resp` and no state change.
- `rst` asserted 2 cycles into SERVE_D:
  - Next cycle is IDLE with all outputs 0.
  - No `d_pmem_resp` is produced.
  - The next request is served normally.
